config_stream_loader: RTL and testbench

- Upstream feeder of the tile configuration bus (`config_addr`/`config_data`) consumed by every tile's address matchers.
- Accepts a byte stream with a valid/ready handshake and assembles 8-byte records: 4-byte address, then 4-byte data, each LSB first.
- Issues each record as a single-cycle configuration write pulse, then spaces writes apart so tile config registers can settle.
- Stops on a terminator record and reports completion.

---
 rtl/config_stream_loader.sv | 141 ++++++++++++++
 tb/tb_config_stream_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_stream_loader.sv
// Assembles valid/ready byte-stream records into single-cycle config bus writes, spaced by GAP_CYCLES.
// Optional checksum byte per record is enabled by defining CONFIG_STREAM_LOADER_CHECKSUM_EN.
module config_stream_loader #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [31:0] TERMINATOR = 32'hFFFF_FFFF,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_byte,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [31:0]        config_addr,
  output logic [31:0]        config_data,
  output logic               config_valid,
  output logic [COUNT_W-1:0] record_count,
  output logic               done,
  output logic               error
);

  // state   | meaning
  // COLLECT | accepting stream bytes into the shadow registers
  // ISSUE   | one-cycle config write strobe
  // GAP     | settle time after a write, stream stalled
  // DONE    | terminator seen, idle until reset
  typedef enum logic [1:0] {S_COLLECT, S_ISSUE, S_GAP, S_DONE} state_t;

  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
  logic [31:0] data_sh;
  logic [7:0]  csum_sh;
  logic        error_q;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
  logic [23:0] data_sh;
`endif

  state_t           state, next_state;
  logic [3:0]       byte_idx;
  logic [31:0]      addr_sh;
  logic [31:0]      rec_data;
  logic [GAP_W-1:0] gap_cnt;
  logic             xfer;
  logic             last_xfer;
  logic             rec_good;

  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && (byte_idx == LAST_IDX);

`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
  assign rec_good = (csum_sh == in_byte);
  assign rec_data = data_sh;
  assign error    = error_q;
`else
  // Without a checksum byte the top data byte arrives on the deciding transfer itself.
  assign rec_good = 1'b1;
  assign rec_data = {in_byte, data_sh};
  assign error    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_COLLECT;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    in_ready     = 1'b0;
    config_valid = 1'b0;
    done         = 1'b0;
    case (state)
      S_COLLECT: begin
        in_ready = 1'b1;
        if (last_xfer && rec_good)
          next_state = (addr_sh == TERMINATOR) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        config_valid = 1'b1;
        next_state   = (GAP_CYCLES > 0) ? S_GAP : S_COLLECT;
      end
      S_GAP: begin
        if (gap_cnt == GAP_W'(1)) next_state = S_COLLECT;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: next_state = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx     <= '0;
      addr_sh      <= '0;
      data_sh      <= '0;
      config_addr  <= '0;
      config_data  <= '0;
      record_count <= '0;
      gap_cnt      <= '0;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
      csum_sh      <= '0;
      error_q      <= 1'b0;
`endif
    end else begin
      if (xfer) begin
        case (byte_idx)
          4'd0: addr_sh[7:0]   <= in_byte;
          4'd1: addr_sh[15:8]  <= in_byte;
          4'd2: addr_sh[23:16] <= in_byte;
          4'd3: addr_sh[31:24] <= in_byte;
          4'd4: data_sh[7:0]   <= in_byte;
          4'd5: data_sh[15:8]  <= in_byte;
          4'd6: data_sh[23:16] <= in_byte;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
          4'd7: data_sh[31:24] <= in_byte;
`endif
          default: ;
        endcase
        byte_idx <= last_xfer ? 4'd0 : byte_idx + 4'd1;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
        if (byte_idx == 4'd0)          csum_sh <= in_byte;
        else if (byte_idx != LAST_IDX) csum_sh <= csum_sh ^ in_byte;
        if (last_xfer && !rec_good)    error_q <= 1'b1;
`endif
      end
      if (state == S_COLLECT && next_state == S_ISSUE) begin
        config_addr <= addr_sh;
        config_data <= rec_data;
      end
      if (state == S_ISSUE) begin
        if (record_count != '1) record_count <= record_count + 1'b1;
        gap_cnt <= GAP_LOAD;
      end
      if (state == S_GAP) gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_config_stream_loader.sv
// Randomized bench for config_stream_loader against a record-level reference model.
// Honours CONFIG_STREAM_LOADER_CHECKSUM_EN to match the DUT build.
module tb_config_stream_loader;
  localparam int          GAP  = 2;
  localparam int          CW   = 4;
  localparam logic [31:0] TERM = 32'hFFFF_FFFF;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
  localparam int REC_LEN = 9;
`else
  localparam int REC_LEN = 8;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_byte = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   config_addr, config_data;
  logic          config_valid;
  logic [CW-1:0] record_count;
  logic          done, error;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  config_stream_loader #(.GAP_CYCLES(GAP), .TERMINATOR(TERM), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .config_addr(config_addr), .config_data(config_data), .config_valid(config_valid),
    .record_count(record_count), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes queue into a record; a good non-terminator record blocks the
  // stream for 1+GAP cycles, the first of which carries the write strobe.
  logic [7:0]    m_q[$];
  int            m_busy = 0;
  bit            m_strobe = 0, m_done = 0, m_error = 0, armed = 0, m_nxt, m_ok;
  logic [31:0]   m_addr = 0, m_data = 0, m_a, m_d;
  logic [CW-1:0] m_count = 0;
  logic [7:0]    m_x;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_busy = 0; m_strobe = 0; m_done = 0; m_error = 0;
      m_addr = 0; m_data = 0; m_count = 0;
    end else begin
      m_nxt = 0;
      if (m_done) begin
      end else if (m_busy > 0) begin
        if (m_strobe && m_count != {CW{1'b1}}) m_count = m_count + 1'b1;
        m_busy--;
      end else if (in_valid) begin
        m_q.push_back(in_byte);
        if (m_q.size() == REC_LEN) begin
          m_a = {m_q[3], m_q[2], m_q[1], m_q[0]};
          m_d = {m_q[7], m_q[6], m_q[5], m_q[4]};
          m_ok = 1;
`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
          m_x = 8'h00;
          for (int i = 0; i < 8; i++) m_x = m_x ^ m_q[i];
          m_ok = (m_x == m_q[8]);
`endif
          if (!m_ok) m_error = 1;
          else if (m_a == TERM) m_done = 1;
          else begin
            m_addr = m_a; m_data = m_d; m_busy = 1 + GAP; m_nxt = 1;
          end
          m_q.delete();
        end
      end
      m_strobe = m_nxt;
    end
    armed = 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      check("in_ready", in_ready, (!m_done && m_busy == 0));
      check("config_valid", config_valid, m_strobe);
      check("config_addr", config_addr, m_addr);
      check("config_data", config_data, m_data);
      check("record_count", record_count, m_count);
      check("done", done, m_done);
      check("error", error, m_error);
      if (config_valid === 1'b1) strobes++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit took = 0;
    int guard = 0;
    if (stall && $urandom_range(0, 3) == 0) begin
      in_valid = 0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    in_valid = 1;
    in_byte  = b;
    while (!took && guard < 100) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    check("handshake", took, 1);
  endtask

  // stall_at >= 0 inserts a 5-cycle in_valid gap before that byte; bad corrupts the checksum.
  task automatic send_record(input logic [31:0] a, input logic [31:0] d, input bit stall,
                             input int stall_at, input bit bad);
    logic [7:0] b[9];
    for (int i = 0; i < 4; i++) begin
      b[i]   = a[8*i +: 8];
      b[i+4] = d[8*i +: 8];
    end
    b[8] = 8'h00;
    for (int i = 0; i < 8; i++) b[8] = b[8] ^ b[i];
    if (bad) b[8] = b[8] ^ 8'h5A;
    for (int i = 0; i < REC_LEN; i++) begin
      if (i == stall_at) begin
        in_valid = 0;
        repeat (5) @(posedge clk);
        #1;
      end
      send_byte(b[i], stall);
    end
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  logic [31:0] ra, rd;
  int s0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_config_valid", config_valid, 0);
    check("rst_record_count", record_count, 0);
    check("rst_config_addr", config_addr, 0);
    @(posedge clk); #1;

    // single record: strobe right after last byte, ready low for 1+GAP cycles
    s0 = strobes;
    send_record(32'h0003_0001, 32'hDEAD_BEEF, 0, -1, 0);
    @(negedge clk);
    check("t1_strobe", config_valid, 1);
    check("t1_ready0", in_ready, 0);
    @(negedge clk); check("t1_ready1", in_ready, 0);
    @(negedge clk); check("t1_ready2", in_ready, 0);
    @(negedge clk); check("t1_ready3", in_ready, 1);
    check("t1_addr", config_addr, 32'h0003_0001);
    check("t1_data", config_data, 32'hDEAD_BEEF);
    check("t1_count", record_count, 1);
    check("t1_strobes", strobes - s0, 1);
    @(posedge clk); #1;

    // back-to-back records with a mid-record stall
    do_reset();
    s0 = strobes;
    send_record($urandom & 32'h7FFF_FFFF, $urandom, 0, -1, 0);
    send_record(32'h0001_0002, 32'h1234_5678, 0, 3, 0);
    idle(5);
    check("t2_addr", config_addr, 32'h0001_0002);
    check("t2_data", config_data, 32'h1234_5678);
    check("t2_count", record_count, 2);
    check("t2_strobes", strobes - s0, 2);

    // random records, including one differing from the terminator by a single bit
    send_record(32'hFFFF_FFFE, $urandom, 1, -1, 0);
    for (int n = 0; n < 10; n++) begin
      ra = $urandom;
      if (ra == TERM) ra = 32'h0;
      send_record(ra, $urandom, 1, -1, 0);
    end
    idle(4);

    // reset landing on the ISSUE cycle
    do_reset();
    send_record(32'h0000_0042, 32'h0000_0099, 0, -1, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("issue_reset_valid", config_valid, 0);
    check("issue_reset_count", record_count, 0);
    @(posedge clk); #1;

    // saturation of the narrow counter
    do_reset();
    s0 = strobes;
    for (int n = 0; n < 17; n++) begin
      ra = $urandom & 32'h7FFF_FFFF;
      send_record(ra, $urandom, 1, -1, 0);
    end
    idle(4);
    check("sat_count", record_count, 4'hF);
    check("sat_strobes", strobes - s0, 17);

`ifdef CONFIG_STREAM_LOADER_CHECKSUM_EN
    do_reset();
    send_record(32'h0000_0001, 32'h0000_0002, 0, -1, 0);
    idle(4);
    check("cs_good_count", record_count, 1);
    check("cs_good_error", error, 0);
    send_record(32'h0000_0001, 32'h0000_0002, 0, -1, 1);
    idle(4);
    check("cs_bad_count", record_count, 1);
    check("cs_bad_error", error, 1);
    send_record(TERM, 32'h0, 0, -1, 1);
    idle(2);
    check("cs_bad_term_done", done, 0);
    send_record(32'h0000_0003, 32'h0000_0004, 0, -1, 0);
    idle(4);
    check("cs_next_count", record_count, 2);
    check("cs_next_addr", config_addr, 32'h0000_0003);
    check("cs_sticky_error", error, 1);
`endif

    // reset after 5 bytes discards the partial record
    do_reset();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
    do_reset();
    s0 = strobes;
    send_record(32'h0000_0010, 32'h0000_00AA, 0, -1, 0);
    idle(4);
    check("t4_addr", config_addr, 32'h0000_0010);
    check("t4_data", config_data, 32'h0000_00AA);
    check("t4_count", record_count, 1);
    check("t4_strobes", strobes - s0, 1);

    // terminator with arbitrary data, then ignored bytes
    s0 = strobes;
    rd = $urandom;
    send_record(TERM, rd, 0, -1, 0);
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      in_byte = 8'($urandom);
      @(negedge clk);
      check("t3_ready_low", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(negedge clk);
    check("t3_done", done, 1);
    check("t3_count", record_count, 1);
    check("t3_strobes", strobes - s0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
